morse_tx: RTL and testbench
===========================

Name: morse_tx

Overview:
Morse transmitter: the output direction of the button-driven Morse entry path. A 4-symbol code word is accepted and played out as timed on/off keying on one output line, for an LED or buzzer. The block uses the same code-word format the entry path produces, so a captured symbol can be looped straight back out. One clock domain, derived from the 27 MHz board clock.

Parameters:
UNIT_CYCLES, 6750000, clock cycles per Morse time unit (250 ms at 27 MHz); legal range is 2 or more.
MAX_SYM, 4, number of symbol slots in the code word; fixed, not intended for override.

Ports:
CLKin   input   1  system clock, 27 MHz on board.
rst_n   input   1  asynchronous, active-low reset.
start   input   1  request to transmit; sampled on every CLKin rising edge.
code    input   4  symbol bits; bit i is symbol i; 0 = dot, 1 = dash; bit 0 is sent first.
len     input   3  number of symbols to send; 1..4 valid; 5..7 are clamped to 4; 0 is invalid.
abort   input   1  synchronous cancel of any transmission in progress.
key     output  1  keying line; 1 = tone or light on.
busy    output  1  high while a transmission is in progress.
done    output  1  one-cycle pulse when a transmission completes normally.

Behaviour:
- Reset (rst_n=0, asynchronous): FSM goes to IDLE.
  - key=0, busy=0, done=0.
  - Unit counter and symbol index cleared.
  - Takes effect immediately, including mid-transmission; no done is generated.
- Timing unit U = UNIT_CYCLES cycles. Element lengths:
  - dot mark = 1U; dash mark = 3U.
  - gap between elements = 1U of key=0.
  - trailing letter gap = 3U of key=0, sent after the last element.
- Acceptance: start=1 with FSM in IDLE, len≠0 and abort=0 at edge k.
  - code and len (after clamping) are latched.
  - Unit counter and symbol index are zeroed.
  - From cycle k+1: busy=1, and key=1 for the first mark.
  - start=1 with len=0 is ignored: no busy, no done.
  - start while busy is ignored; the latched code is unaffected by input changes.
- FSM states: IDLE -> MARK -> (SPACE -> MARK)* -> LGAP -> IDLE.
  - MARK: key=1 for 1U or 3U, selected by the latched bit at the symbol index.
  - SPACE: key=0 for 1U, then the index increments.
  - At the end of the last MARK, go to LGAP instead of SPACE.
  - LGAP: key=0 for 3U.
- Completion: on the cycle after LGAP ends, the FSM is in IDLE with busy=0 and done=1 for exactly 1 cycle.
  - A new start may be accepted in that same cycle.
- Total busy cycles = U·(Σ element units) + U·(n−1) + 3U.
- abort=1 in any non-IDLE state: next cycle FSM=IDLE, key=0, busy=0, done=0. abort in IDLE has no effect. abort takes priority over start.
- Unit counter width is $clog2(3·UNIT_CYCLES). It wraps to 0 at the end of each element or gap; there is no free-running drift.
- key, busy and done are all registered outputs, with no combinational path from the inputs.

Decomposition:
- morse_pkg:
  - localparams DOT=1'b0, DASH=1'b1, MAX_SYM=4, DOT_UNITS=1, DASH_UNITS=3, ESPACE_UNITS=1, LGAP_UNITS=3.
  - State enum typedef {IDLE, MARK, SPACE, LGAP}.
  - The receiver also imports these for code-word consistency.
- One sub-module, morse_unit_timer:
  - Loadable down-counter in units of UNIT_CYCLES.
  - Load value is 1 or 3 units.
  - Outputs a single-cycle expiry strobe.
  - The FSM instantiates one copy.

Test Plan (UNIT_CYCLES=4, accept edge = cycle 0):
1. "E": code=0000, len=1 -> key=1 on cycles 1–4; key=0 on 5–16; busy=1 on 1–16; done=1 on cycle 17 only.
2. "A": code=0010, len=2 -> key=1 on 1–4; 0 on 5–8; 1 on 9–20; 0 on 21–32; done at 33.
3. Clamp: code=1111, len=7 -> four dashes (12 cycles each, 4-cycle gaps), then a 12-cycle letter gap; busy for 72 cycles; done at 73. len=0 with start -> busy stays 0, no done.
4. start pulsed again with a different code at cycle 6 of test 2 -> ignored, waveform identical to test 2. A new start coinciding with done -> accepted; key=1 on the next cycle.
5. abort at cycle 10 of test 2 -> cycle 11: key=0, busy=0, and done never asserts. rst_n low at cycle 3 of test 1 -> key and busy drop immediately (asynchronously); no done after release.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared Morse code-word definitions for the transmit and receive paths.
package morse_pkg;

  localparam logic DOT          = 1'b0;
  localparam logic DASH         = 1'b1;
  localparam int   MAX_SYM      = 4;
  localparam int   DOT_UNITS    = 1;
  localparam int   DASH_UNITS   = 3;
  localparam int   ESPACE_UNITS = 1;
  localparam int   LGAP_UNITS   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2,
    LGAP  = 2'd3
  } morse_state_t;

  // Mark length in time units for one symbol bit.
  function automatic logic [1:0] mark_units(input logic sym);
    return (sym == DASH) ? 2'(DASH_UNITS) : 2'(DOT_UNITS);
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Loadable down-counter measuring 1 or 3 Morse time units; strobes expire
// for one cycle on the last cycle of the loaded interval.
module morse_unit_timer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 6750000
) (
  input  logic       CLKin,
  input  logic       rst_n,
  input  logic       load,
  input  logic [1:0] units,
  input  logic       clear,
  output logic       expire
);

  localparam int CW = $clog2(3 * UNIT_CYCLES);
  localparam logic [CW-1:0] ONE_U   = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] THREE_U = CW'(3 * UNIT_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          running;

  // The loaded value is one less than the interval so expire lands on its last cycle.
  assign expire = running && (cnt == '0);

  // Count down while running; a load in the expiry cycle restarts without a gap.
  always_ff @(posedge CLKin or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (load) begin
      cnt     <= (units == 2'(DASH_UNITS)) ? THREE_U : ONE_U;
      running <= 1'b1;
    end else if (expire) begin
      running <= 1'b0;
    end else if (running) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/morse_tx.sv
// Morse transmitter: plays a latched code word out as timed on/off keying.
//
// state | meaning
// IDLE  | waiting for start; done pulses here for one cycle after LGAP
// MARK  | key on for 1U (dot) or 3U (dash) of symbol idx
// SPACE | key off for 1U between elements, then idx advances
// LGAP  | key off for 3U trailing letter gap
module morse_tx
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 6750000
) (
  input  logic               CLKin,
  input  logic               rst_n,
  input  logic               start,
  input  logic [MAX_SYM-1:0] code,
  input  logic [2:0]         len,
  input  logic               abort,
  output logic               key,
  output logic               busy,
  output logic               done
);

  morse_state_t       state;
  logic [MAX_SYM-1:0] code_q;
  logic [1:0]         last_idx;
  logic [1:0]         idx;
  logic [1:0]         idx_nxt;
  logic               accept;
  logic               t_load;
  logic [1:0]         t_units;
  logic               t_clear;
  logic               t_expire;

  assign idx_nxt = idx + 2'd1;
  assign accept  = (state == IDLE) && start && (len != 3'd0) && !abort;

  // Timer control: load the next interval exactly when the current one expires.
  always_comb begin
    t_load  = 1'b0;
    t_units = 2'(DOT_UNITS);
    t_clear = abort && (state != IDLE);
    if (!t_clear) begin
      case (state)
        IDLE: begin
          if (accept) begin
            t_load  = 1'b1;
            t_units = mark_units(code[0]);
          end
        end
        MARK: begin
          if (t_expire) begin
            t_load  = 1'b1;
            t_units = (idx == last_idx) ? 2'(LGAP_UNITS) : 2'(ESPACE_UNITS);
          end
        end
        SPACE: begin
          if (t_expire) begin
            t_load  = 1'b1;
            t_units = mark_units(code_q[idx_nxt]);
          end
        end
        default: ;
      endcase
    end
  end

  morse_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_timer (
    .CLKin (CLKin),
    .rst_n (rst_n),
    .load  (t_load),
    .units (t_units),
    .clear (t_clear),
    .expire(t_expire)
  );

  // Sequencing FSM with registered key/busy/done; abort overrides everything.
  always_ff @(posedge CLKin or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      code_q   <= '0;
      last_idx <= 2'd0;
      idx      <= 2'd0;
      key      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && (state != IDLE)) begin
        state <= IDLE;
        idx   <= 2'd0;
        key   <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              code_q   <= code;
              last_idx <= (len >= 3'(MAX_SYM)) ? 2'(MAX_SYM - 1) : 2'(len - 3'd1);
              idx      <= 2'd0;
              state    <= MARK;
              key      <= 1'b1;
              busy     <= 1'b1;
            end
          end
          MARK: begin
            if (t_expire) begin
              state <= (idx == last_idx) ? LGAP : SPACE;
              key   <= 1'b0;
            end
          end
          SPACE: begin
            if (t_expire) begin
              idx   <= idx_nxt;
              state <= MARK;
              key   <= 1'b1;
            end
          end
          LGAP: begin
            if (t_expire) begin
              state <= IDLE;
              idx   <= 2'd0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_tx.sv
// Scoreboard bench for morse_tx: stimulus pushes the expected key waveform,
// a negedge monitor captures each busy window and compares on its end.
module tb_morse_tx;

  localparam int U = 4;

  logic       CLKin = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] code  = 4'd0;
  logic [2:0] len   = 3'd0;
  logic       abort = 1'b0;
  logic       key;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  // Expected transmissions: per entry a length, a done flag, and its key bits.
  int exp_len[$];
  bit exp_done[$];
  bit exp_bits[$];

  bit cap[$];
  bit prev_busy = 1'b0;

  morse_tx #(.UNIT_CYCLES(U)) dut (
    .CLKin(CLKin),
    .rst_n(rst_n),
    .start(start),
    .code (code),
    .len  (len),
    .abort(abort),
    .key  (key),
    .busy (busy),
    .done (done)
  );

  always #5 CLKin = ~CLKin;

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, required, $time);
    end
  endtask

  // Busy length from the closed-form unit count of the word.
  function automatic int tx_total(input logic [3:0] c, input logic [2:0] l);
    int n;
    int units;
    n = (l > 3'd4) ? 4 : int'(l);
    units = 0;
    for (int i = 0; i < n; i++) units += c[i] ? 3 : 1;
    return U * units + U * (n - 1) + 3 * U;
  endfunction

  // Expected waveform built element by element; abort truncates it.
  task automatic push_model(input logic [3:0] c, input logic [2:0] l, input int abort_at);
    bit q[$];
    int n;
    n = (l > 3'd4) ? 4 : int'(l);
    for (int i = 0; i < n; i++) begin
      repeat ((c[i] ? 3 : 1) * U) q.push_back(1'b1);
      if (i < n - 1) repeat (U) q.push_back(1'b0);
    end
    repeat (3 * U) q.push_back(1'b0);
    if (abort_at > 0) begin
      while (q.size() > abort_at) void'(q.pop_back());
    end
    exp_len.push_back(q.size());
    exp_done.push_back(abort_at == 0);
    foreach (q[i]) exp_bits.push_back(q[i]);
  endtask

  // Issue one transmission; optional abort on cycle abort_at and a foreign
  // start on cycle 6. Returns in the cycle after the end (done cycle).
  task automatic send_tx(input logic [3:0] c, input logic [2:0] l,
                         input int abort_at, input bit poke);
    int total;
    int last;
    total = tx_total(c, l);
    push_model(c, l, abort_at);
    start = 1'b1; code = c; len = l;
    @(posedge CLKin); #1;
    start = 1'b0;
    last = (abort_at > 0) ? abort_at : total;
    for (int cyc = 1; cyc <= last; cyc++) begin
      abort = (cyc == abort_at);
      if (poke && cyc == 6) begin
        start = 1'b1; code = ~c; len = 3'd4;
      end else begin
        start = 1'b0; code = c; len = l;
      end
      @(posedge CLKin); #1;
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge CLKin); #1;
    end
  endtask

  // Monitor: capture key during busy, score each window when busy falls.
  always @(negedge CLKin) begin
    if (rst_n) begin
      if (busy) begin
        cap.push_back(key);
        check("done_while_busy", int'(done), 0);
      end else if (prev_busy) begin
        if (exp_len.size() == 0) begin
          check("unexpected_tx", 1, 0);
        end else begin
          int el;
          int bad;
          bit ed;
          el = exp_len.pop_front();
          ed = exp_done.pop_front();
          bad = -1;
          for (int i = 0; i < el; i++) begin
            bit eb;
            eb = exp_bits.pop_front();
            if (bad < 0 && (i >= cap.size() || cap[i] != eb)) bad = i;
          end
          check("busy_cycles", cap.size(), el);
          check("key_first_bad_cycle", bad, -1);
          check("done_pulse", int'(done), int'(ed));
        end
        cap.delete();
      end else begin
        check("idle_done", int'(done), 0);
        check("idle_key", int'(key), 0);
      end
    end
    prev_busy <= busy && rst_n;
  end

  // Reset-terminated window: compare what was captured before reset hit.
  task automatic score_reset_window();
    int el;
    int bad;
    el = exp_len.pop_front();
    void'(exp_done.pop_front());
    bad = -1;
    for (int i = 0; i < el; i++) begin
      bit eb;
      eb = exp_bits.pop_front();
      if (bad < 0 && (i >= cap.size() || cap[i] != eb)) bad = i;
    end
    check("reset_busy_cycles", cap.size(), el);
    check("reset_key_bad_cycle", bad, -1);
    cap.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    logic [3:0] rc;
    logic [2:0] rl;

    rst_n = 1'b0;
    #23;
    check("reset_key", int'(key), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    @(posedge CLKin); #1;
    rst_n = 1'b1;
    idle_cycles(2);

    // E, then A, then four clamped dashes
    send_tx(4'b0000, 3'd1, 0, 1'b0);
    idle_cycles(2);
    send_tx(4'b0010, 3'd2, 0, 1'b0);
    idle_cycles(1);
    send_tx(4'b1111, 3'd7, 0, 1'b0);
    idle_cycles(1);

    // len=0 start is ignored
    start = 1'b1; code = 4'b1010; len = 3'd0;
    @(posedge CLKin); #1;
    start = 1'b0;
    check("len0_busy", int'(busy), 0);
    idle_cycles(3);

    // A with an ignored start at cycle 6, then a start in the done cycle
    send_tx(4'b0010, 3'd2, 0, 1'b1);
    send_tx(4'b0001, 3'd1, 0, 1'b0);
    check("back_to_back_key", int'(key), 0);
    idle_cycles(2);

    // A aborted at cycle 10
    send_tx(4'b0010, 3'd2, 10, 1'b0);
    check("abort_busy", int'(busy), 0);
    check("abort_key", int'(key), 0);
    idle_cycles(3);

    // Asynchronous reset during E
    push_model(4'b0000, 3'd1, 2);
    start = 1'b1; code = 4'b0000; len = 3'd1;
    @(posedge CLKin); #1;
    start = 1'b0;
    idle_cycles(2);
    rst_n = 1'b0;
    #1;
    check("async_rst_key", int'(key), 0);
    check("async_rst_busy", int'(busy), 0);
    score_reset_window();
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(4);

    // Randomized words, lengths, aborts, pokes and gaps
    for (int t = 0; t < 14; t++) begin
      rc = 4'($urandom);
      rl = 3'($urandom_range(1, 7));
      a = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, tx_total(rc, rl))) : 0;
      send_tx(rc, rl, a, 1'($urandom));
      idle_cycles($urandom_range(0, 3));
    end

    idle_cycles(4);
    check("scoreboard_empty", exp_len.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
